// File: rtl/comparador_pkg.sv
// Shared state encodings and sizing helper for the level supervisor.
package comparador_pkg;

   localparam logic [1:0] EST_ABAIXO = 2'b00;
   localparam logic [1:0] EST_DENTRO = 2'b01;
   localparam logic [1:0] EST_ACIMA  = 2'b10;

   // Bits needed to hold values 0..v-1 (minimum 1).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/comparador_n.sv
// Unsigned magnitude comparator over WIDTH+1-bit operands, purely combinational.
module comparador_n #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   output logic           aeqb,
   output logic           agtb,
   output logic           altb
);

   assign aeqb = (a == b);
   assign agtb = (a > b);
   assign altb = (a < b);

endmodule

// File: rtl/comparador_histerese.sv
// Level supervisor: classifies samples against low/high limits with hysteresis
// and debounce; estado, level flags, change pulse and config error are registered.
module comparador_histerese
   import comparador_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int HYST  = 1,
   parameter int DEB   = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             amostra_valida,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] lim_baixo,
   input  logic [WIDTH-1:0] lim_alto,
   output logic [1:0]       estado,
   output logic             nivel_baixo,
   output logic             nivel_alto,
   output logic             mudou,
   output logic             cfg_erro
);

   localparam int CW = clog2(DEB + 1);
   localparam logic [WIDTH:0] HYST_X = (WIDTH + 1)'(HYST);

   logic [WIDTH:0] a_x, lb_x, la_x, lbh_x, ah_x;
   logic [4:0]     cmp_eq, cmp_gt, cmp_lt;

   // One extra bit keeps lim_baixo+HYST and a+HYST from wrapping.
   assign a_x   = {1'b0, a};
   assign lb_x  = {1'b0, lim_baixo};
   assign la_x  = {1'b0, lim_alto};
   assign lbh_x = lb_x + HYST_X;
   assign ah_x  = a_x + HYST_X;

   comparador_n #(.WIDTH(WIDTH)) u_a_lb  (.a(a_x),  .b(lb_x),  .aeqb(cmp_eq[0]), .agtb(cmp_gt[0]), .altb(cmp_lt[0]));
   comparador_n #(.WIDTH(WIDTH)) u_a_la  (.a(a_x),  .b(la_x),  .aeqb(cmp_eq[1]), .agtb(cmp_gt[1]), .altb(cmp_lt[1]));
   comparador_n #(.WIDTH(WIDTH)) u_a_lbh (.a(a_x),  .b(lbh_x), .aeqb(cmp_eq[2]), .agtb(cmp_gt[2]), .altb(cmp_lt[2]));
   comparador_n #(.WIDTH(WIDTH)) u_ah_la (.a(ah_x), .b(la_x),  .aeqb(cmp_eq[3]), .agtb(cmp_gt[3]), .altb(cmp_lt[3]));
   comparador_n #(.WIDTH(WIDTH)) u_lb_la (.a(lb_x), .b(la_x),  .aeqb(cmp_eq[4]), .agtb(cmp_gt[4]), .altb(cmp_lt[4]));

   logic a_lt_baixo, a_gt_alto, a_sai_baixo, a_sai_alto, cfg_bad;
   logic unused_cmp;

   assign a_lt_baixo  = cmp_lt[0];
   assign a_gt_alto   = cmp_gt[1];
   assign a_sai_baixo = cmp_gt[2] | cmp_eq[2];
   assign a_sai_alto  = cmp_lt[3] | cmp_eq[3];
   assign cfg_bad     = cmp_gt[4];
   assign unused_cmp  = ^{cmp_eq[0], cmp_gt[0], cmp_eq[1], cmp_lt[1],
                          cmp_lt[2], cmp_gt[3], cmp_eq[4], cmp_lt[4]};

   logic [1:0]    estado_q, estado_d;
   logic [1:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_step;
   logic          nivel_baixo_q, nivel_baixo_d;
   logic          nivel_alto_q, nivel_alto_d;
   logic          mudou_q, mudou_d;
   logic          cfg_erro_q, cfg_erro_d;
   logic [1:0]    req;

   always_comb begin
      req = estado_q;
      case (estado_q)
         EST_ABAIXO: begin
            if (a_gt_alto)        req = EST_ACIMA;
            else if (a_sai_baixo) req = EST_DENTRO;
            else                  req = EST_ABAIXO;
         end
         EST_ACIMA: begin
            if (a_lt_baixo)       req = EST_ABAIXO;
            else if (a_sai_alto)  req = EST_DENTRO;
            else                  req = EST_ACIMA;
         end
         default: begin
            if (a_lt_baixo)       req = EST_ABAIXO;
            else if (a_gt_alto)   req = EST_ACIMA;
            else                  req = EST_DENTRO;
         end
      endcase
   end

   always_comb begin
      estado_d = estado_q;
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      cnt_step = cnt_q;
      mudou_d  = 1'b0;
      // Invalid limits freeze the state and discard any partial run.
      if (cfg_bad) begin
         cnt_d  = '0;
         cand_d = estado_q;
      end else if (amostra_valida) begin
         if (req == estado_q) begin
            cnt_d = '0;
         end else begin
            if (req == cand_q) begin
               cnt_step = cnt_q + CW'(1);
            end else begin
               cand_d   = req;
               cnt_step = CW'(1);
            end
            if (cnt_step == CW'(DEB)) begin
               estado_d = req;
               cnt_d    = '0;
               mudou_d  = 1'b1;
            end else begin
               cnt_d = cnt_step;
            end
         end
      end
      nivel_baixo_d = (estado_d == EST_ABAIXO);
      nivel_alto_d  = (estado_d == EST_ACIMA);
      cfg_erro_d    = cfg_bad;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q      <= EST_DENTRO;
         cand_q        <= EST_DENTRO;
         cnt_q         <= '0;
         nivel_baixo_q <= 1'b0;
         nivel_alto_q  <= 1'b0;
         mudou_q       <= 1'b0;
         cfg_erro_q    <= 1'b0;
      end else begin
         estado_q      <= estado_d;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         nivel_baixo_q <= nivel_baixo_d;
         nivel_alto_q  <= nivel_alto_d;
         mudou_q       <= mudou_d;
         cfg_erro_q    <= cfg_erro_d;
      end
   end

   assign estado      = estado_q;
   assign nivel_baixo = nivel_baixo_q;
   assign nivel_alto  = nivel_alto_q;
   assign mudou       = mudou_q;
   assign cfg_erro    = cfg_erro_q;

endmodule

// File: tb/tb_comparador_histerese.sv
// Directed bench for comparador_histerese with a behavioural reference model.
module tb_comparador_histerese;

   localparam int WIDTH = 4;
   localparam int HYST  = 1;
   localparam int DEB   = 3;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             amostra_valida = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] lim_baixo = 4'd4;
   logic [WIDTH-1:0] lim_alto = 4'd10;
   logic [1:0]       estado;
   logic             nivel_baixo, nivel_alto, mudou, cfg_erro;

   int n_cmp = 0;
   int n_err = 0;

   comparador_histerese #(.WIDTH(WIDTH), .HYST(HYST), .DEB(DEB)) dut (
      .clk(clk), .reset(reset), .amostra_valida(amostra_valida), .a(a),
      .lim_baixo(lim_baixo), .lim_alto(lim_alto), .estado(estado),
      .nivel_baixo(nivel_baixo), .nivel_alto(nivel_alto), .mudou(mudou),
      .cfg_erro(cfg_erro)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: 0=below, 1=inside, 2=above; run = length of the current
   // agreeing streak of valid samples asking for the same non-current level.
   int m_est, m_cand, m_run, m_mud, m_cfg;

   function automatic int wanted(int cur, int s, int lo, int hi);
      if (cur == 0) return (s > hi) ? 2 : ((s >= lo + HYST) ? 1 : 0);
      if (cur == 2) return (s < lo) ? 0 : ((s + HYST <= hi) ? 1 : 2);
      return (s < lo) ? 0 : ((s > hi) ? 2 : 1);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_est = 1; m_cand = 1; m_run = 0; m_mud = 0; m_cfg = 0;
      end else begin
         int lo, hi, w;
         lo = int'(lim_baixo);
         hi = int'(lim_alto);
         m_mud = 0;
         m_cfg = (lo > hi) ? 1 : 0;
         if (lo > hi) begin
            m_run = 0;
            m_cand = m_est;
         end else if (amostra_valida) begin
            w = wanted(m_est, int'(a), lo, hi);
            if (w == m_est) m_run = 0;
            else begin
               m_run = (w == m_cand) ? m_run + 1 : 1;
               m_cand = w;
               if (m_run >= DEB) begin
                  m_est = w; m_run = 0; m_mud = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("model_estado", int'(estado), m_est);
         chk("model_nivel_baixo", int'(nivel_baixo), (m_est == 0) ? 1 : 0);
         chk("model_nivel_alto", int'(nivel_alto), (m_est == 2) ? 1 : 0);
         chk("model_mudou", int'(mudou), m_mud);
         chk("model_cfg_erro", int'(cfg_erro), m_cfg);
      end
   end

   task automatic step(input logic v, input int av);
      amostra_valida = v;
      a = WIDTH'(av);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int av, input int n);
      for (int i = 0; i < n; i++) step(1'b1, av);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_estado", int'(estado), 1);
      chk("reset_flags", int'({nivel_baixo, nivel_alto, mudou, cfg_erro}), 0);
      reset = 1'b0;

      // Below-limit entry after three samples, single-cycle pulse.
      run(3, 2);
      chk("t2_wait_estado", int'(estado), 1);
      run(3, 1);
      chk("t2_estado", int'(estado), 0);
      chk("t2_nivel_baixo", int'(nivel_baixo), 1);
      chk("t2_mudou", int'(mudou), 1);
      run(3, 1);
      chk("t2_mudou_drop", int'(mudou), 0);

      // Hysteresis on leaving ABAIXO.
      run(4, 5);
      chk("t3_hyst_hold", int'(estado), 0);
      run(5, 3);
      chk("t3_estado", int'(estado), 1);
      chk("t3_mudou", int'(mudou), 1);

      // Interrupted run, then ACIMA, hysteresis, back to DENTRO.
      run(11, 2); run(7, 1); run(11, 2);
      chk("t4_no_change", int'(estado), 1);
      run(11, 1);
      chk("t4_acima", int'(estado), 2);
      chk("t4_nivel_alto", int'(nivel_alto), 1);
      run(10, 4);
      chk("t4_hyst_hold", int'(estado), 2);
      run(9, 3);
      chk("t4_dentro", int'(estado), 1);

      // Idle gaps do not break the run.
      step(1, 11); step(0, 11); step(0, 11);
      chk("t5_idle_mudou", int'(mudou), 0);
      step(1, 11); step(0, 11);
      chk("t5_before", int'(estado), 1);
      step(1, 11);
      chk("t5_acima", int'(estado), 2);

      // Asynchronous reset in the middle of a run clears the counter.
      run(3, 2);
      #2 reset = 1'b1;
      #1;
      chk("t1_async_estado", int'(estado), 1);
      chk("t1_async_flags", int'({nivel_baixo, nivel_alto, mudou, cfg_erro}), 0);
      @(negedge clk);
      reset = 1'b0;
      run(3, 2);
      chk("t1_cnt_cleared", int'(estado), 1);
      run(3, 1);
      chk("t1_after", int'(estado), 0);

      // Configuration error.
      run(5, 3);
      chk("t6_start", int'(estado), 1);
      lim_baixo = 4'd12;
      step(1, 2);
      chk("t6_cfg_erro", int'(cfg_erro), 1);
      run(2, 4);
      chk("t6_held", int'(estado), 1);
      lim_baixo = 4'd4;
      step(1, 2);
      chk("t6_cfg_clear", int'(cfg_erro), 0);
      run(2, 1);
      chk("t6_wait", int'(estado), 1);
      run(2, 1);
      chk("t6_abaixo", int'(estado), 0);

      // Equal limits and unwrapped lim_baixo+HYST.
      lim_baixo = 4'd7; lim_alto = 4'd7;
      run(7, 3);
      chk("eq_hold_abaixo", int'(estado), 0);
      run(8, 3);
      chk("eq_acima", int'(estado), 2);
      run(7, 3);
      chk("eq_hold_acima", int'(estado), 2);
      run(0, 3);
      chk("eq_abaixo", int'(estado), 0);
      lim_baixo = 4'd15; lim_alto = 4'd15;
      run(15, 4);
      chk("nowrap_hold", int'(estado), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
